// File: rtl/tx_pkg.sv
// Shared defaults, tap-entry type and accumulator sizing for the QPSK
// polyphase pulse-shaping interpolator.
package tx_pkg;

    localparam int UPSAMPLE_DEF   = 4;
    localparam int NCOEF_DEF      = 24;
    localparam int COEF_NBITS_DEF = 8;
    localparam int COEF_FBITS_DEF = 7;
    localparam int OUT_NBITS_DEF  = 8;
    localparam int OUT_FBITS_DEF  = 6;

    // One entry of a tap line: a null slot contributes nothing to the sum.
    typedef struct packed {
        logic present;
        logic sign;
    } tap_t;

    // NTAPS signed terms of COEF_NBITS each cannot overflow this width.
    function automatic int acc_width(input int coef_nbits, input int ntaps);
        return coef_nbits + $clog2(ntaps) + 1;
    endfunction

endpackage

// File: rtl/tx_round_sat.sv
// Round-half-up, arithmetic shift and clip of one polyphase sum to the
// output sample format.
module tx_round_sat #(
    parameter int IN_W       = 12,
    parameter int COEF_FBITS = 7,
    parameter int OUT_NBITS  = 8,
    parameter int OUT_FBITS  = 6
) (
    input  logic signed [IN_W-1:0]      acc_i,
    output logic signed [OUT_NBITS-1:0] sample_o,
    output logic                        sat_o
);

    localparam int D = COEF_FBITS - OUT_FBITS;
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((2 ** (OUT_NBITS-1)) - 1);
    localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

    logic signed [IN_W:0] wide;
    logic signed [IN_W:0] scaled;

    assign wide = {acc_i[IN_W-1], acc_i};

    generate
        if (D > 0) begin : g_round
            localparam logic signed [IN_W:0] HALF = (IN_W+1)'(2 ** (D-1));
            assign scaled = (wide + HALF) >>> D;
        end else begin : g_pass
            assign scaled = wide;
        end
    endgenerate

    // Clip the scaled value into the signed output range and flag it.
    always_comb begin
        sat_o    = 1'b0;
        sample_o = scaled[OUT_NBITS-1:0];
        if (scaled > MAX_V) begin
            sat_o    = 1'b1;
            sample_o = MAX_V[OUT_NBITS-1:0];
        end else if (scaled < MIN_V) begin
            sat_o    = 1'b1;
            sample_o = MIN_V[OUT_NBITS-1:0];
        end
    end

endmodule

// File: rtl/tx_polyfir.sv
// Two-channel (I/Q) polyphase pulse-shaping interpolator: one symbol per
// UPSAMPLE clocks in, one shaped I/Q sample pair per clock out.
module tx_polyfir
    import tx_pkg::*;
#(
    parameter int UPSAMPLE   = UPSAMPLE_DEF,
    parameter int NCOEF      = NCOEF_DEF,
    parameter int COEF_NBITS = COEF_NBITS_DEF,
    parameter int COEF_FBITS = COEF_FBITS_DEF,
    parameter int OUT_NBITS  = OUT_NBITS_DEF,
    parameter int OUT_FBITS  = OUT_FBITS_DEF,
    parameter logic [NCOEF*COEF_NBITS-1:0] COEF = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [1:0]                    sym_in,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    input  logic                          coef_we,
    input  logic [$clog2(NCOEF)-1:0]      coef_addr,
    input  logic signed [COEF_NBITS-1:0]  coef_data,
    output logic signed [OUT_NBITS-1:0]   out_i,
    output logic signed [OUT_NBITS-1:0]   out_q,
    output logic                          out_valid,
    output logic                          sat_i,
    output logic                          sat_q,
    output logic                          underrun
);

    localparam int NTAPS = NCOEF / UPSAMPLE;
    localparam int ACC_W = acc_width(COEF_NBITS, NTAPS);
    localparam int PW    = $clog2(UPSAMPLE);
    localparam int AW    = $clog2(NCOEF);
    localparam logic [PW-1:0] LAST_PHASE = PW'(UPSAMPLE - 1);

    logic [PW-1:0]                 phase_q, phase_d;
    logic                          slot;
    tap_t                          new_i, new_q;
    tap_t                          taps_i_q [NTAPS];
    tap_t                          taps_q_q [NTAPS];
    logic signed [COEF_NBITS-1:0]  coef_q [NCOEF];

    logic [AW-1:0]                 idx;
    logic signed [ACC_W-1:0]       term;
    logic signed [ACC_W-1:0]       sum_i, sum_q;

    logic signed [OUT_NBITS-1:0]   rs_i, rs_q;
    logic                          rs_sat_i, rs_sat_q;

    logic signed [OUT_NBITS-1:0]   out_i_q, out_q_q;
    logic                          out_valid_q, sat_i_q, sat_q_q, underrun_q;

    // Slot edge detection, handshake and next phase; a missing symbol
    // enters the tap line as a null so stale data never leaks out.
    always_comb begin
        slot          = en && (phase_q == LAST_PHASE);
        sym_ready     = slot;
        phase_d       = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
        new_i.present = sym_valid;
        new_i.sign    = sym_valid & sym_in[1];
        new_q.present = sym_valid;
        new_q.sign    = sym_valid & sym_in[0];
    end

    // Polyphase sums: tap k uses coef[k*UPSAMPLE + phase], signed by the symbol bit.
    always_comb begin
        sum_i = '0;
        sum_q = '0;
        idx   = '0;
        term  = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            idx  = AW'(k * UPSAMPLE) + AW'(phase_q);
            term = {{(ACC_W-COEF_NBITS){coef_q[idx][COEF_NBITS-1]}}, coef_q[idx]};
            if (taps_i_q[k].present) begin
                sum_i = taps_i_q[k].sign ? sum_i + term : sum_i - term;
            end
            if (taps_q_q[k].present) begin
                sum_q = taps_q_q[k].sign ? sum_q + term : sum_q - term;
            end
        end
    end

    tx_round_sat #(
        .IN_W       (ACC_W),
        .COEF_FBITS (COEF_FBITS),
        .OUT_NBITS  (OUT_NBITS),
        .OUT_FBITS  (OUT_FBITS)
    ) u_rs_i (
        .acc_i    (sum_i),
        .sample_o (rs_i),
        .sat_o    (rs_sat_i)
    );

    tx_round_sat #(
        .IN_W       (ACC_W),
        .COEF_FBITS (COEF_FBITS),
        .OUT_NBITS  (OUT_NBITS),
        .OUT_FBITS  (OUT_FBITS)
    ) u_rs_q (
        .acc_i    (sum_q),
        .sample_o (rs_q),
        .sat_o    (rs_sat_q)
    );

    // Phase, tap lines and registered outputs; everything but the strobes holds while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q     <= LAST_PHASE;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            sat_i_q     <= 1'b0;
            sat_q_q     <= 1'b0;
            underrun_q  <= 1'b0;
            for (int unsigned k = 0; k < NTAPS; k++) begin
                taps_i_q[k] <= '0;
                taps_q_q[k] <= '0;
            end
        end else begin
            out_valid_q <= en;
            underrun_q  <= slot && !sym_valid;
            if (en) begin
                phase_q <= phase_d;
                out_i_q <= rs_i;
                out_q_q <= rs_q;
                sat_i_q <= rs_sat_i;
                sat_q_q <= rs_sat_q;
                if (slot) begin
                    taps_i_q[0] <= new_i;
                    taps_q_q[0] <= new_q;
                    for (int unsigned k = 1; k < NTAPS; k++) begin
                        taps_i_q[k] <= taps_i_q[k-1];
                        taps_q_q[k] <= taps_q_q[k-1];
                    end
                end
            end
        end
    end

    // Coefficient RAM: reset image has coef[0] in the MSBs; writes ignore en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NCOEF; i++) begin
                coef_q[i] <= COEF[(NCOEF-1-i)*COEF_NBITS +: COEF_NBITS];
            end
        end else if (coef_we && (int'(coef_addr) < NCOEF)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign sat_i     = sat_i_q;
    assign sat_q     = sat_q_q;
    assign underrun  = underrun_q;

endmodule
